// File: rtl/piso_regn_pkg.sv
// Shared state encoding and default word width for the parallel-in serial-out shifter.
// Pure declarations, no latency or flow control of its own.
package piso_regn_pkg;

    localparam int DEFAULT_N = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/piso_regn_if.sv
// Load/serial-out bundle between a word producer (master) and the shifter (slave).
// No latency or flow control of its own; the shifter ignores ld while it is occupied.
interface piso_regn_if
    import piso_regn_pkg::*;
#(
    parameter int N = DEFAULT_N
) ();

    logic [N-1:0] data_in;
    logic         ld;
    logic         sout;
    logic         busy;
    logic         done;

    modport master (
        output data_in,
        output ld,
        input  sout,
        input  busy,
        input  done
    );

    modport slave (
        input  data_in,
        input  ld,
        output sout,
        output busy,
        output done
    );

endinterface

// File: rtl/piso_regn.sv
// Serializes an N-bit word MSB first: first bit right after the load edge, N+2 cycles per word.
// No backpressure path: ld is only honoured in IDLE and silently dropped while shifting or done.
module piso_regn
    import piso_regn_pkg::*;
#(
    parameter int N = DEFAULT_N
) (
    input  logic       clk,
    input  logic       rst,
    piso_regn_if.slave bus
);

    localparam int CW = $clog2(N);
    localparam logic [CW-1:0] LAST_CNT = CW'(N - 1);

    state_t        state_q, state_d;
    logic [N-1:0]  sh_q, sh_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          sout_q, sout_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;

    always_comb begin
        state_d = state_q;
        sh_d    = sh_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (bus.ld) begin
                    sh_d    = bus.data_in;
                    cnt_d   = '0;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                // Counter saturates at N-1 so it never wraps inside a word.
                if (cnt_q == LAST_CNT) begin
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                    sh_d  = {sh_q[N-2:0], 1'b0};
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // Outputs follow the next state so they line up with it after the edge.
        busy_d = (state_d == SHIFT);
        done_d = (state_d == DONE);
        sout_d = (state_d == SHIFT) & sh_d[N-1];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            sh_q    <= '0;
            cnt_q   <= '0;
            sout_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sh_q    <= sh_d;
            cnt_q   <= cnt_d;
            sout_q  <= sout_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign bus.sout = sout_q;
    assign bus.busy = busy_q;
    assign bus.done = done_q;

endmodule

// File: tb/tb_piso_regn.sv
// Directed bench for piso_regn at N=8 and N=2 with hand-derived bit sequences.
module tb_piso_regn;

    logic clk = 1'b0;
    logic rst;
    int   n_chk  = 0;
    int   n_fail = 0;
    int   dn8    = 0;

    always #5 clk = ~clk;

    piso_regn_if #(.N(8)) bus8 ();
    piso_regn_if #(.N(2)) bus2 ();

    piso_regn #(.N(8)) u_dut8 (.clk(clk), .rst(rst), .bus(bus8.slave));
    piso_regn #(.N(2)) u_dut2 (.clk(clk), .rst(rst), .bus(bus2.slave));

    always @(negedge clk) if (bus8.done === 1'b1) dn8 <= dn8 + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: run did not finish, got timeout, want completion");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, want %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Entered just after the load edge; leaves one cycle after the done pulse.
    task automatic check_word(input logic [7:0] w, input string tg, input int ign_i);
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("%s_sout%0d", tg, i), int'(bus8.sout), int'(w[7-i]));
            chk($sformatf("%s_busy%0d", tg, i), int'(bus8.busy), 1);
            chk($sformatf("%s_done%0d", tg, i), int'(bus8.done), 0);
            if (ign_i >= 0 && i == ign_i) begin
                bus8.ld      = 1'b1;
                bus8.data_in = 8'hFF;
            end else if (ign_i >= 0 && i == ign_i + 1) begin
                bus8.ld = 1'b0;
            end
            tick();
        end
        chk({tg, "_done_pulse"}, int'(bus8.done), 1);
        chk({tg, "_done_busy"},  int'(bus8.busy), 0);
        chk({tg, "_done_sout"},  int'(bus8.sout), 0);
        tick();
        chk({tg, "_idle_done"},  int'(bus8.done), 0);
        chk({tg, "_idle_busy"},  int'(bus8.busy), 0);
    endtask

    task automatic send8(input logic [7:0] w, input string tg, input int ign_i);
        bus8.data_in = w;
        bus8.ld      = 1'b1;
        tick();
        bus8.ld      = 1'b0;
        bus8.data_in = ~w;
        check_word(w, tg, ign_i);
    endtask

    initial begin
        logic [7:0] w;
        int d0;

        rst          = 1'b1;
        bus8.ld      = 1'b0;
        bus8.data_in = 8'h00;
        bus2.ld      = 1'b0;
        bus2.data_in = 2'b00;
        #1;
        chk("rst_sout", int'(bus8.sout), 0);
        chk("rst_busy", int'(bus8.busy), 0);
        chk("rst_done", int'(bus8.done), 0);
        tick();
        tick();
        rst = 1'b0;
        tick();
        chk("post_rst_busy", int'(bus8.busy), 0);

        send8(8'hA5, "a5", -1);

        d0 = dn8;
        send8(8'h3C, "ign", 2);
        chk("ign_done_cnt", dn8 - d0, 1);

        // ld held high: second word must start exactly 10 edges after the first.
        bus8.data_in = 8'h81;
        bus8.ld      = 1'b1;
        tick();
        bus8.data_in = 8'h7E;
        check_word(8'h81, "b2b0", -1);
        tick();
        bus8.ld = 1'b0;
        check_word(8'h7E, "b2b1", -1);

        bus8.data_in = 8'hF0;
        bus8.ld      = 1'b1;
        tick();
        bus8.ld = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("f0_sout%0d", i), int'(bus8.sout), 1);
            tick();
        end
        chk("f0_busy_pre", int'(bus8.busy), 1);
        d0 = dn8;
        #1;
        rst = 1'b1;
        #1;
        chk("arst_sout", int'(bus8.sout), 0);
        chk("arst_busy", int'(bus8.busy), 0);
        chk("arst_done", int'(bus8.done), 0);
        repeat (3) tick();
        rst = 1'b0;
        repeat (12) tick();
        chk("arst_no_done", dn8 - d0, 0);
        chk("arst_idle_busy", int'(bus8.busy), 0);
        send8(8'h01, "post_arst", -1);

        d0 = dn8;
        for (int j = 0; j < 10; j++) begin
            w = 8'($urandom_range(0, 255));
            send8(w, $sformatf("rnd%0d", j), -1);
            tick();
            tick();
        end
        chk("rnd_done_cnt", dn8 - d0, 10);

        bus2.data_in = 2'b10;
        bus2.ld      = 1'b1;
        tick();
        bus2.ld      = 1'b0;
        bus2.data_in = 2'b01;
        chk("n2_sout0", int'(bus2.sout), 1);
        chk("n2_busy0", int'(bus2.busy), 1);
        tick();
        chk("n2_sout1", int'(bus2.sout), 0);
        chk("n2_busy1", int'(bus2.busy), 1);
        tick();
        chk("n2_done",      int'(bus2.done), 1);
        chk("n2_done_busy", int'(bus2.busy), 0);
        chk("n2_done_sout", int'(bus2.sout), 0);
        tick();
        chk("n2_idle_done", int'(bus2.done), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
